// File: rtl/vga_timing_pkg.sv
// Nominal 640x480 VGA timing constants and the receive-side lock FSM encoding.
// Shared between the sync generator and the sync decoder.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 11;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 31;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_OFS    = H_SYNC + H_BACK;
    localparam int unsigned V_OFS    = V_SYNC + V_BACK;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned ERR_W    = 8;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registers an active-low sync input and flags its falling edge in the same
// cycle the input is first seen low. Idle level after reset is high.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall_c
);

    logic din_r;

    // previous-cycle sample of the sync input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_r <= 1'b1;
        end else begin
            din_r <= din;
        end
    end

    assign fall_c = din_r & ~din;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hsync/vsync, measures line
// and frame lengths and reports lock against the configured timing.
// Optional feature macro: VGA_RX_ERR_CNT_EN (saturating sync error counter).
// Timing defaults to nominal 640x480; the CFG_* parameters allow scaled-down
// timing for fast loopback tests.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned CFG_H_ACTIVE = H_ACTIVE,
    parameter int unsigned CFG_H_FRONT  = H_FRONT,
    parameter int unsigned CFG_H_SYNC   = H_SYNC,
    parameter int unsigned CFG_H_BACK   = H_BACK,
    parameter int unsigned CFG_V_ACTIVE = V_ACTIVE,
    parameter int unsigned CFG_V_FRONT  = V_FRONT,
    parameter int unsigned CFG_V_SYNC   = V_SYNC,
    parameter int unsigned CFG_V_BACK   = V_BACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             pixel_valid,
    output logic             locked,
    output logic             frame_start,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] HT_W    = CNT_W'(CFG_H_ACTIVE + CFG_H_FRONT + CFG_H_SYNC + CFG_H_BACK);
    localparam logic [CNT_W-1:0] VT_W    = CNT_W'(CFG_V_ACTIVE + CFG_V_FRONT + CFG_V_SYNC + CFG_V_BACK);
    localparam logic [CNT_W-1:0] HOFS_W  = CNT_W'(CFG_H_SYNC + CFG_H_BACK);
    localparam logic [CNT_W-1:0] VOFS_W  = CNT_W'(CFG_V_SYNC + CFG_V_BACK);
    localparam logic [CNT_W-1:0] HEND_W  = CNT_W'(CFG_H_SYNC + CFG_H_BACK + CFG_H_ACTIVE);
    localparam logic [CNT_W-1:0] VEND_W  = CNT_W'(CFG_V_SYNC + CFG_V_BACK + CFG_V_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE_W   = CNT_W'(1);

    logic             hs_fall_c;
    logic             vs_fall_c;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             line_ok;
    logic             line_ok_nxt;
    logic             sync_err_c;
    logic             line_bad_c;
    logic             frame_bad_c;
    logic             in_window_c;

    sync_edge_det u_hs_det (
        .clk    (clk),
        .rst    (rst),
        .din    (hsync),
        .fall_c (hs_fall_c)
    );

    sync_edge_det u_vs_det (
        .clk    (clk),
        .rst    (rst),
        .din    (vsync),
        .fall_c (vs_fall_c)
    );

    // a line/frame is bad when the interval closed by this sync fall is off-nominal
    assign line_bad_c  = hs_fall_c && ((h_cnt + ONE_W) != HT_W);
    assign frame_bad_c = vs_fall_c && ((v_cnt + ONE_W) != VT_W);
    assign in_window_c = (h_cnt >= HOFS_W) && (h_cnt < HEND_W) &&
                         (v_cnt >= VOFS_W) && (v_cnt < VEND_W);

    // pixel counter within the line, and length of the line just closed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt    <= '0;
            line_len <= '0;
        end else if (hs_fall_c) begin
            h_cnt    <= '0;
            line_len <= h_cnt + ONE_W;
        end else if (h_cnt != CNT_MAX) begin
            h_cnt    <= h_cnt + ONE_W;
        end
    end

    // line counter within the frame; a coincident vsync fall takes priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_cnt       <= '0;
            frame_lines <= '0;
        end else if (vs_fall_c) begin
            v_cnt       <= '0;
            frame_lines <= v_cnt + ONE_W;
        end else if (hs_fall_c && (v_cnt != CNT_MAX)) begin
            v_cnt       <= v_cnt + ONE_W;
        end
    end

    // lock FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SEARCH;
            line_ok <= 1'b0;
        end else begin
            state   <= state_nxt;
            line_ok <= line_ok_nxt;
        end
    end

    // lock FSM next state: qualify one full frame, then watch for violations
    always_comb begin
        state_nxt   = state;
        line_ok_nxt = line_ok;
        sync_err_c  = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall_c) begin
                    state_nxt   = MEASURE;
                    line_ok_nxt = 1'b1;
                end
            end
            MEASURE: begin
                if (line_bad_c) begin
                    line_ok_nxt = 1'b0;
                end
                if (vs_fall_c) begin
                    if (line_ok && !line_bad_c && !frame_bad_c) begin
                        state_nxt = LOCKED;
                    end
                    line_ok_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (line_bad_c || frame_bad_c || (h_cnt == CNT_MAX)) begin
                    sync_err_c = 1'b1;
                    state_nxt  = SEARCH;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    // registered status and coordinate outputs, one cycle behind the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x           <= '0;
            y           <= '0;
            pixel_valid <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            x           <= h_cnt - HOFS_W;
            y           <= v_cnt - VOFS_W;
            pixel_valid <= (state == LOCKED) && in_window_c;
            locked      <= (state == LOCKED);
            frame_start <= vs_fall_c;
            sync_err    <= sync_err_c;
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    // saturating count of sync errors, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (sync_err_c && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule
